// File: rtl/xor_accum_pkg.sv
// rtl/xor_accum_pkg.sv - shared state encoding and default sizes for the XOR frame accumulator
package xor_accum_pkg;

    localparam int STATE_W       = 2;
    localparam int WIDTH_DEF     = 8;
    localparam int FRAME_LEN_DEF = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/xor_frame_chan.sv
// rtl/xor_frame_chan.sv - one lane: frame FSM, running XOR, word counter, sticky error
module xor_frame_chan
    import xor_accum_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_load,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_next;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d, err_set;
    logic             accept;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        err_set  = 1'b0;
        acc_next = in_load ? in_data : (acc_q ^ in_data);
        cnt_inc  = cnt_q + CNT_ONE;
        accept   = in_valid && (state_q != ST_HOLD);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_load) begin
                        acc_d   = acc_next;
                        cnt_d   = CNT_ONE;
                        state_d = (FRAME_LEN == 1) ? ST_HOLD : ST_ACC;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_ACC: begin
                if (accept) begin
                    acc_d = acc_next;
                    // A load mid-frame abandons the partial frame and starts over.
                    if (in_load) begin
                        cnt_d   = CNT_ONE;
                        err_set = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == FRAME_LAST) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh error wins over a clear landing on the same edge.
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = acc_q;
    assign word_cnt  = cnt_q;
    assign err       = err_q;

endmodule

// File: rtl/xor_frame_accum.sv
// rtl/xor_frame_accum.sv - NCH independent XOR frame accumulator lanes on shared buses
module xor_frame_accum
    import xor_accum_pkg::*;
#(
    parameter  int WIDTH     = WIDTH_DEF,
    parameter  int NCH       = 4,
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_load,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH*CNT_W-1:0] word_cnt,
    output logic [NCH-1:0]       err,
    input  logic                 err_clr
);

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        xor_frame_chan #(
            .WIDTH     (WIDTH),
            .FRAME_LEN (FRAME_LEN),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[i]),
            .in_load   (in_load[i]),
            .in_data   (in_data[i*WIDTH +: WIDTH]),
            .in_ready  (in_ready[i]),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH]),
            .word_cnt  (word_cnt[i*CNT_W +: CNT_W]),
            .err       (err[i]),
            .err_clr   (err_clr)
        );
    end

endmodule

// File: tb/tb_xor_frame_accum.sv
// tb/tb_xor_frame_accum.sv - randomized and directed checks of xor_frame_accum against a frame-queue model
module tb_xor_frame_accum;

    localparam int NCH = 4;
    localparam int FL  = 4;
    localparam int CW  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      in_valid, in_load, out_ready;
    logic [NCH*8-1:0]    in_data;
    logic [NCH-1:0]      in_ready, out_valid, err;
    logic [NCH*8-1:0]    out_data;
    logic [NCH*CW-1:0]   word_cnt;
    logic                err_clr;

    logic                v1, l1, r1, rdy1, ov1, e1;
    logic [7:0]          d1, od1;
    logic [0:0]          wc1;

    int ncomp = 0;
    int nfail = 0;

    logic [7:0] fq [NCH][$];
    bit         cons [NCH];
    bit         merr [NCH];
    bit         h1, c1, me1;
    logic [7:0] a1;
    logic [7:0] pat [4];

    xor_frame_accum #(.WIDTH(8), .NCH(NCH), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_load(in_load), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .word_cnt(word_cnt), .err(err), .err_clr(err_clr)
    );

    xor_frame_accum #(.WIDTH(8), .NCH(1), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_load(l1), .in_data(d1),
        .in_ready(rdy1), .out_valid(ov1), .out_ready(r1), .out_data(od1),
        .word_cnt(wc1), .err(e1), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xsum(int l);
        logic [7:0] s = 8'h00;
        foreach (fq[l][k]) s = s ^ fq[l][k];
        return s;
    endfunction

    function automatic bit holding(int l);
        return (fq[l].size() == FL) && !cons[l];
    endfunction

    function automatic bit active(int l);
        return (fq[l].size() > 0) && (fq[l].size() < FL);
    endfunction

    task automatic chk(string tag, int lane, logic [31:0] obs, logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s lane%0d: observed %0h expected %0h", tag, lane, obs, exp);
        end
    endtask

    task automatic model_step();
        bit set;
        logic [7:0] d;
        if (rst) begin
            for (int l = 0; l < NCH; l++) begin
                fq[l].delete();
                cons[l] = 1'b0;
                merr[l] = 1'b0;
            end
            h1 = 1'b0; c1 = 1'b0; me1 = 1'b0; a1 = 8'h00;
        end else begin
            for (int l = 0; l < NCH; l++) begin
                set = 1'b0;
                d   = in_data[l*8 +: 8];
                if (holding(l)) begin
                    if (out_ready[l]) cons[l] = 1'b1;
                end else if (in_valid[l]) begin
                    if (in_load[l]) begin
                        if (active(l)) set = 1'b1;
                        fq[l].delete();
                        fq[l].push_back(d);
                        cons[l] = 1'b0;
                    end else if (active(l)) begin
                        fq[l].push_back(d);
                    end else begin
                        set = 1'b1;
                    end
                end
                merr[l] = set | (merr[l] & !err_clr);
            end
            set = 1'b0;
            if (h1) begin
                if (r1) h1 = 1'b0;
            end else if (v1) begin
                if (l1) begin
                    a1 = d1; c1 = 1'b1; h1 = 1'b1;
                end else begin
                    set = 1'b1;
                end
            end
            me1 = set | (me1 & !err_clr);
        end
    endtask

    task automatic check_all();
        for (int l = 0; l < NCH; l++) begin
            chk("out_valid", l, 32'(out_valid[l]), 32'(holding(l)));
            chk("in_ready",  l, 32'(in_ready[l]),  32'(!holding(l)));
            chk("out_data",  l, 32'(out_data[l*8 +: 8]), 32'(xsum(l)));
            chk("word_cnt",  l, 32'(word_cnt[l*CW +: CW]), 32'(fq[l].size()));
            chk("err",       l, 32'(err[l]), 32'(merr[l]));
        end
        chk("fl1_out_valid", 0, 32'(ov1),  32'(h1));
        chk("fl1_in_ready",  0, 32'(rdy1), 32'(!h1));
        chk("fl1_out_data",  0, 32'(od1),  32'(a1));
        chk("fl1_word_cnt",  0, 32'(wc1),  32'(c1));
        chk("fl1_err",       0, 32'(e1),   32'(me1));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_load = '0; in_data = '0; err_clr = 1'b0;
        v1 = 1'b0; l1 = 1'b0; d1 = 8'h00;
    endtask

    initial begin
        pat[0] = 8'hA5; pat[1] = 8'h0F; pat[2] = 8'hF0; pat[3] = 8'h01;
        rst = 1'b1; out_ready = '0; r1 = 1'b0;
        idle_inputs();

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'($urandom); in_load = 4'($urandom); in_data = $urandom;
            out_ready = 4'($urandom); err_clr = 1'($urandom);
            v1 = 1'($urandom); l1 = 1'($urandom); d1 = 8'($urandom); r1 = 1'($urandom);
            tick();
        end
        rst = 1'b0; idle_inputs(); out_ready = '0; r1 = 1'b0;
        tick();
        chk("rst_in_ready", 0, 32'(in_ready), 32'hF);
        chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
        chk("rst_word_cnt", 0, 32'(word_cnt), 32'h0);
        chk("rst_out_data", 0, out_data, 32'h0);

        // FRAME_LEN=1 corner: load goes straight to hold
        v1 = 1'b1; l1 = 1'b1; d1 = 8'h3C;
        tick();
        v1 = 1'b0; l1 = 1'b0;
        chk("fl1_hold", 0, 32'(ov1), 32'h1);
        chk("fl1_data", 0, 32'(od1), 32'h3C);
        r1 = 1'b1;
        tick();
        chk("fl1_release", 0, 32'(ov1), 32'h0);

        // Lane 0 basic frame, consumer ready
        out_ready = '1;
        for (int i = 0; i < 4; i++) begin
            in_valid[0] = 1'b1; in_load[0] = (i == 0); in_data[7:0] = pat[i];
            tick();
        end
        idle_inputs();
        chk("t2_valid", 0, 32'(out_valid[0]), 32'h1);
        chk("t2_data", 0, 32'(out_data[7:0]), 32'h5B);
        tick();
        chk("t2_idle", 0, 32'(out_valid[0]), 32'h0);

        // Backpressure
        out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid[0] = 1'b1; in_load[0] = (i == 0); in_data[7:0] = pat[i];
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1; in_load[0] = 1'($urandom); in_data[7:0] = 8'($urandom);
            tick();
            chk("t3_hold_data", 0, 32'(out_data[7:0]), 32'h5B);
            chk("t3_in_ready", 0, 32'(in_ready[0]), 32'h0);
            chk("t3_err", 0, 32'(err[0]), 32'h0);
        end
        idle_inputs(); out_ready = '1;
        tick();
        chk("t3_release", 0, 32'(out_valid[0]), 32'h0);

        // Protocol errors
        in_valid[0] = 1'b1; in_load[0] = 1'b0; in_data[7:0] = 8'($urandom);
        tick();
        chk("t4_err_idle", 0, 32'(err[0]), 32'h1);
        chk("t4_acc_kept", 0, 32'(out_data[7:0]), 32'h5B);
        in_load[0] = 1'b1; in_data[7:0] = 8'($urandom); tick();
        in_load[0] = 1'b0; in_data[7:0] = 8'($urandom); tick();
        in_load[0] = 1'b1; in_data[7:0] = 8'h77; tick();
        chk("t4_restart_cnt", 0, 32'(word_cnt[CW-1:0]), 32'h1);
        chk("t4_restart_data", 0, 32'(out_data[7:0]), 32'h77);
        idle_inputs();
        in_valid[1] = 1'b1; in_data[15:8] = 8'($urandom); err_clr = 1'b1;
        tick();
        chk("t4_clr_vs_set", 1, 32'(err[1]), 32'h1);
        chk("t4_clr", 0, 32'(err[0]), 32'h0);
        idle_inputs(); err_clr = 1'b1;
        tick();
        chk("t4_clr_all", 0, 32'(err), 32'h0);
        idle_inputs();
        in_valid[0] = 1'b1; in_load[0] = 1'b1; tick();
        in_load[0] = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        idle_inputs(); tick();

        // All lanes, lane 2 stalled
        out_ready = 4'b1011;
        for (int i = 0; i < FL; i++) begin
            in_valid = '1; in_load = (i == 0) ? 4'hF : 4'h0; in_data = $urandom;
            tick();
        end
        idle_inputs();
        chk("t5_all_done", 0, 32'(out_valid), 32'hF);
        for (int i = 0; i < 3; i++) tick();
        chk("t5_lane2_hold", 2, 32'(out_valid), 32'h4);
        out_ready = '1;
        tick();

        // Reset mid-frame and in hold
        out_ready = 4'b0111;
        for (int i = 0; i < FL; i++) begin
            in_valid = {1'b1, 2'b00, (i < 2)}; in_load = (i == 0) ? 4'h9 : 4'h0; in_data = $urandom;
            tick();
        end
        idle_inputs();
        chk("t6_pre_cnt", 0, 32'(word_cnt[CW-1:0]), 32'h2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_cnt", 0, 32'(word_cnt), 32'h0);
        chk("t6_rst_valid", 0, 32'(out_valid), 32'h0);
        out_ready = '1;
        for (int i = 0; i < FL; i++) begin
            in_valid = '1; in_load = (i == 0) ? 4'hF : 4'h0; in_data = $urandom;
            tick();
        end
        idle_inputs(); tick();

        // Random soak
        for (int n = 0; n < 400; n++) begin
            in_valid = 4'($urandom); in_data = $urandom; out_ready = 4'($urandom);
            for (int l = 0; l < NCH; l++) in_load[l] = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            v1 = 1'($urandom); l1 = ($urandom_range(0, 2) != 0); d1 = 8'($urandom); r1 = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
